serdes_link: RTL
================

// Module: serdes_link
// PURPOSE
//  Parametrised full-duplex serial link endpoint: TX path serialises parallel words with a valid/ready handshake;
//  RX path deserialises a bit stream framed by a sync strobe. Generalises fixed power-of-2 SerDes to any width,
//  either bit order and gapless back-to-back frames. Sits between MIPS-side word buses and single-wire inter-block links.
// PARAMETERS
//  WIDTH     32  data bits per frame; any integer >= 2 (not restricted to powers of 2)
//  MSB_FIRST 0   0: bit 0 transmitted/received first; 1: bit WIDTH-1 first
//  CNTW      $clog2(WIDTH+1)  bit-index counter width (derived, do not override)
// PORTS
//  Clk       in  1      clock; all state updates on posedge only
//  Arst_n    in  1      asynchronous active-low reset
//  Tx_data   in  WIDTH  parallel word to send
//  Tx_valid  in  1      Tx_data valid
//  Tx_ready  out 1      TX can accept a word this cycle
//  Tx_sdo    out 1      serial data out (registered)
//  Tx_sync   out 1      high during first bit of each TX frame (registered)
//  Tx_busy   out 1      TX frame in progress
//  Rx_sdi    in  1      serial data in
//  Rx_sync   in  1      frame start strobe, coincident with first bit
//  Rx_data   out WIDTH  received word, held until next Rx_valid
//  Rx_valid  out 1      one-cycle pulse: Rx_data updated
//  Rx_abort  out 1      one-cycle pulse: frame restarted by Rx_sync before completion
//  Rx_perr   out 1      parity error, qualified by Rx_valid (tied 0 when parity disabled)
// BEHAVIOUR
//  Reset (Arst_n=0, async): Tx_ready=1, Tx_sdo=0, Tx_sync=0, Tx_busy=0, Rx_data=0, Rx_valid=0, Rx_abort=0,
//   Rx_perr=0; both FSMs -> IDLE, counters 0. Reset mid-frame discards the frame; no partial output.
//  FRAME_LEN = WIDTH (+1 if parity). Bit order per MSB_FIRST on both paths.
//  TX FSM IDLE/SHIFT:
//   - Accept = Tx_valid & Tx_ready at posedge k: word loaded, SHIFT, first bit on Tx_sdo with Tx_sync=1 after edge k.
//   - One bit per cycle; Tx_sync=1 only for bit 0 of the frame; Tx_busy=1 for all FRAME_LEN bit cycles.
//   - Tx_ready=1 in IDLE and in the cycle driving the last bit (gapless streaming); else 0.
//   - Accept on last bit: next frame's first bit follows immediately, Tx_sync re-asserts; no idle cycle.
//   - No accept on last bit: -> IDLE, Tx_sdo=0, Tx_sync=0, Tx_busy=0.
//   - Tx_data is sampled only at accept; later changes ignored.
//  RX FSM IDLE/SHIFT:
//   - Each posedge samples Rx_sdi/Rx_sync. Rx_sync=1 starts a frame with that bit as bit 0 (any state).
//   - In SHIFT without Rx_sync: next bit captured, counter++. Rx_sdi ignored in IDLE without Rx_sync.
//   - Edge sampling last bit: Rx_data updated, Rx_valid=1 next cycle, -> IDLE (or stays SHIFT if that edge also
//     sees Rx_sync for a new frame... not possible; Rx_sync on the last-bit edge counts as a new bit 0 and aborts).
//   - Rx_sync while SHIFT with counter in 1..FRAME_LEN-1: Rx_abort pulses 1 cycle, partial word dropped,
//     Rx_data unchanged, new frame starts at that bit.
//   - Loopback (Tx_sdo->Rx_sdi, Tx_sync->Rx_sync): accept at edge k -> Rx_valid high after edge k+FRAME_LEN.
//  TX and RX are independent; simultaneous activity on both is legal.
// CONFIGURATION
//  SERDES_PARITY_EN defined: TX appends even-parity bit (XOR of word) after the WIDTH data bits; RX checks it,
//   Rx_perr = parity mismatch, valid with Rx_valid. Frame = WIDTH+1 cycles.
//  Undefined: no parity bit, frame = WIDTH cycles, Rx_perr constant 0.
// TESTING
//  1. WIDTH=32, LSB-first, loopback, send 32'hA5A5_0F0F -> Tx_sdo bits 1,1,1,1,0,0,0,0,...; Rx_valid at k+32, Rx_data=A5A50F0F.
//  2. Tx_valid held high with 3 words (1,2,3) -> Tx_sync every 32 cycles, no idle gap, 3 Rx_valid pulses with 1,2,3.
//  3. WIDTH=12, MSB_FIRST=1, send 12'h801 -> Tx_sdo 1,0,0,0,0,0,0,0,0,0,0,1; Rx_data=12'h801.
//  4. RX: Rx_sync, 10 bits, Rx_sync again -> Rx_abort pulse, Rx_data unchanged, next full frame received correctly.
//  5. Drop Arst_n mid-frame at bit 7 -> all outputs reset values immediately; next frame clean with Tx_sync on bit 0.
//  6. SERDES_PARITY_EN, send 32'h0000_0001 -> 33rd bit=1, Rx_perr=0; flip parity bit in channel -> Rx_perr=1 with Rx_valid.

Source files
------------

// File: rtl/serdes_link.sv
// Full-duplex serial link endpoint: a valid/ready word serialiser (TX) and a sync-framed deserialiser (RX).
// Optional build macro SERDES_PARITY_EN appends an even-parity bit to every frame and checks it on receive.
module serdes_link #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNTW      = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Arst_n,
  input  logic [WIDTH-1:0] Tx_data,
  input  logic             Tx_valid,
  output logic             Tx_ready,
  output logic             Tx_sdo,
  output logic             Tx_sync,
  output logic             Tx_busy,
  input  logic             Rx_sdi,
  input  logic             Rx_sync,
  output logic [WIDTH-1:0] Rx_data,
  output logic             Rx_valid,
  output logic             Rx_abort,
  output logic             Rx_perr
);

`ifdef SERDES_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int              FRAME_LEN = WIDTH + PAR_BITS;
  localparam logic [CNTW-1:0] LAST_IDX  = CNTW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Maps between word order and line order; a bit reversal is its own inverse,
  // so the same function serves both directions.
  function automatic logic [WIDTH-1:0] to_line_order(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    // NOTE: give the result a full default before the loop so no path leaves bits unassigned.
    r = '0;
    for (int j = 0; j < WIDTH; j++) begin
      r[j] = MSB_FIRST ? w[WIDTH-1-j] : w[j];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- TX path
  state_t                 tx_state;
  logic [CNTW-1:0]        tx_cnt;      // index of the bit currently on Tx_sdo
  logic [FRAME_LEN-2:0]   tx_shreg;    // bits still to send, next one in bit 0
  logic [FRAME_LEN-1:0]   tx_frame;
  logic                   tx_accept;

`ifdef SERDES_PARITY_EN
  assign tx_frame = {^Tx_data, to_line_order(Tx_data)};
`else
  assign tx_frame = to_line_order(Tx_data);
`endif

  // Ready also during the last bit so a waiting word follows with no idle cycle.
  assign Tx_ready  = (tx_state == IDLE) || (tx_cnt == LAST_IDX);
  assign tx_accept = Tx_valid && Tx_ready;

  // NOTE: every register here uses <= so all flops update from pre-edge values.
  always_ff @(posedge Clk or negedge Arst_n) begin
    if (!Arst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_shreg <= '0;
      Tx_sdo   <= 1'b0;
      Tx_sync  <= 1'b0;
      Tx_busy  <= 1'b0;
    end else if (tx_accept) begin
      tx_state <= SHIFT;
      tx_cnt   <= '0;
      tx_shreg <= tx_frame[FRAME_LEN-1:1];
      Tx_sdo   <= tx_frame[0];
      Tx_sync  <= 1'b1;
      Tx_busy  <= 1'b1;
    end else if (tx_state == SHIFT) begin
      if (tx_cnt == LAST_IDX) begin
        tx_state <= IDLE;
        tx_cnt   <= '0;
        Tx_sdo   <= 1'b0;
        Tx_sync  <= 1'b0;
        Tx_busy  <= 1'b0;
      end else begin
        tx_cnt   <= tx_cnt + 1'b1;
        tx_shreg <= tx_shreg >> 1;
        Tx_sdo   <= tx_shreg[0];
        Tx_sync  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  state_t                 rx_state;
  logic [CNTW-1:0]        rx_cnt;      // index of the bit sampled at the coming edge
  logic [FRAME_LEN-2:0]   rx_shreg;    // bits received so far, oldest in bit 0 once full
  logic [FRAME_LEN-1:0]   rx_next;
  logic                   rx_done;

  // Bit i of rx_next is the i-th bit on the line once the last bit arrives.
  assign rx_next = {Rx_sdi, rx_shreg};
  assign rx_done = !Rx_sync && (rx_state == SHIFT) && (rx_cnt == LAST_IDX);

  // NOTE: the shift register is reset along with the FSM; it is tiny and this keeps X out of Rx_data.
  always_ff @(posedge Clk or negedge Arst_n) begin
    if (!Arst_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_shreg <= '0;
      Rx_data  <= '0;
      Rx_valid <= 1'b0;
      Rx_abort <= 1'b0;
    end else begin
      Rx_valid <= 1'b0;
      Rx_abort <= 1'b0;
      if (Rx_sync) begin
        // A sync inside a frame (including on its last bit) drops the partial word.
        Rx_abort <= (rx_state == SHIFT);
        rx_state <= SHIFT;
        rx_cnt   <= CNTW'(1);
        rx_shreg <= rx_next[FRAME_LEN-1:1];
      end else if (rx_state == SHIFT) begin
        rx_shreg <= rx_next[FRAME_LEN-1:1];
        if (rx_done) begin
          Rx_data  <= to_line_order(rx_next[WIDTH-1:0]);
          Rx_valid <= 1'b1;
          rx_state <= IDLE;
          rx_cnt   <= '0;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SERDES_PARITY_EN
  // Even parity over data plus parity bit must come out zero.
  always_ff @(posedge Clk or negedge Arst_n) begin
    if (!Arst_n) begin
      Rx_perr <= 1'b0;
    end else begin
      Rx_perr <= rx_done && (^rx_next);
    end
  end
`else
  assign Rx_perr = 1'b0;
`endif

endmodule
